set_counter_gen: RTL

- Parametrised successor to the contest SET circle-counting engine.
- Takes up to N_CIRCLES circles (centre and radius) on a GRID x GRID integer lattice with coordinates 1..GRID.
- Counts the lattice points that satisfy a selected set expression over those circles.
- Scans LANES points per cycle through a 2-stage pipeline and sits behind the same en/busy/valid handshake as its predecessor.

---
 rtl/set_gen_pkg.sv | 43 ++++
 rtl/set_counter_gen_if.sv | 37 +++
 rtl/set_point_eval.sv | 50 +++++
 rtl/set_counter_gen.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/set_gen_pkg.sv
// rtl/set_gen_pkg.sv - shared types and helpers for the set_counter_gen lattice-point counter
package set_gen_pkg;

    typedef enum logic [2:0] {
        MODE_A    = 3'd0,
        MODE_OR2  = 3'd1,
        MODE_XOR2 = 3'd2,
        MODE_AND2 = 3'd3,
        MODE_TWO  = 3'd4,
        MODE_OR3  = 3'd5,
        MODE_AND3 = 3'd6,
        MODE_ODD  = 3'd7
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic int cnt_w(input int grid);
        return $clog2(grid * grid + 1);
    endfunction

    // m[0]=A, m[1]=B, m[2]=C; C is tied low when only two circles exist
    function automatic logic set_expr(input logic [2:0] m, input mode_e mode);
        logic r;
        case (mode)
            MODE_A:    r = m[0];
            MODE_OR2:  r = m[0] | m[1];
            MODE_XOR2: r = m[0] ^ m[1];
            MODE_AND2: r = m[0] & m[1];
            MODE_TWO:  r = (m[0] & m[1] & ~m[2]) | (m[0] & ~m[1] & m[2]) | (~m[0] & m[1] & m[2]);
            MODE_OR3:  r = |m;
            MODE_AND3: r = &m;
            MODE_ODD:  r = ^m;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/set_counter_gen_if.sv
// rtl/set_counter_gen_if.sv - job handshake bundle for set_counter_gen; map port exists only with SET_MAP_EN
interface set_counter_gen_if #(
    parameter int GRID      = 8,
    parameter int COORD_W   = 4,
    parameter int RAD_W     = 4,
    parameter int N_CIRCLES = 3
);
    localparam int CNT_W = set_gen_pkg::cnt_w(GRID);

    logic                            en;
    logic [N_CIRCLES*2*COORD_W-1:0]  central;
    logic [N_CIRCLES*RAD_W-1:0]      radius;
    logic [2:0]                      mode;
    logic                            busy;
    logic                            valid;
    logic [CNT_W-1:0]                candidate;
`ifdef SET_MAP_EN
    logic [GRID*GRID-1:0]            map;
`endif

    modport master (
        output en, central, radius, mode,
`ifdef SET_MAP_EN
        input  map,
`endif
        input  busy, valid, candidate
    );

    modport slave (
        input  en, central, radius, mode,
`ifdef SET_MAP_EN
        output map,
`endif
        output busy, valid, candidate
    );

endinterface

// File: rtl/set_point_eval.sv
// rtl/set_point_eval.sv - one scan lane: registered squared distances to every centre, then radius compare
module set_point_eval #(
    parameter int COORD_W   = 4,
    parameter int RAD_W     = 4,
    parameter int N_CIRCLES = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [COORD_W-1:0]             px_i,
    input  logic [COORD_W-1:0]             py_i,
    input  logic [N_CIRCLES*2*COORD_W-1:0] central_i,
    input  logic [N_CIRCLES*RAD_W-1:0]     radius_i,
    output logic [N_CIRCLES-1:0]           member_o
);
    localparam int DW  = COORD_W + 1;
    localparam int D2W = 2 * COORD_W + 3;

    for (genvar i = 0; i < N_CIRCLES; i++) begin : g_circ
        localparam int XO = (N_CIRCLES - i) * 2 * COORD_W;

        logic [COORD_W-1:0]    cx;
        logic [COORD_W-1:0]    cy;
        logic [RAD_W-1:0]      r;
        logic signed [DW-1:0]  dx;
        logic signed [DW-1:0]  dy;
        logic signed [D2W-1:0] dxe;
        logic signed [D2W-1:0] dye;
        logic [D2W-1:0]        d2_d;
        logic [D2W-1:0]        d2_q;

        assign cx = central_i[XO-1 -: COORD_W];
        assign cy = central_i[XO-COORD_W-1 -: COORD_W];
        assign r  = radius_i[(N_CIRCLES-i)*RAD_W-1 -: RAD_W];

        // Centres may sit at 0 or beyond GRID, so differences must be signed
        assign dx   = $signed({1'b0, px_i}) - $signed({1'b0, cx});
        assign dy   = $signed({1'b0, py_i}) - $signed({1'b0, cy});
        assign dxe  = D2W'(dx);
        assign dye  = D2W'(dy);
        assign d2_d = $unsigned(dxe * dxe + dye * dye);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) d2_q <= '0;
            else        d2_q <= d2_d;
        end

        assign member_o[i] = (32'(d2_q) <= 32'(r) * 32'(r));
    end

endmodule

// File: rtl/set_counter_gen.sv
// rtl/set_counter_gen.sv - counts lattice points matching a circle set expression; SET_MAP_EN adds a hit bitmap
module set_counter_gen
    import set_gen_pkg::*;
#(
    parameter int GRID      = 8,
    parameter int COORD_W   = 4,
    parameter int RAD_W     = 4,
    parameter int N_CIRCLES = 3,
    parameter int LANES     = 1
) (
    input  logic              clk,
    input  logic              rst,
    set_counter_gen_if.slave  bus
);
    localparam int CNT_W  = cnt_w(GRID);
    localparam int XSTEPS = GRID / LANES;

    state_e                          state_q, state_d;
    logic                            flush_q;
    logic                            v1_q;
    logic [N_CIRCLES*2*COORD_W-1:0]  central_q;
    logic [N_CIRCLES*RAD_W-1:0]      radius_q;
    mode_e                           mode_q;
    logic [COORD_W-1:0]              xg_q;
    logic [COORD_W-1:0]              y_q;
    logic [COORD_W-1:0]              py;
    logic [CNT_W-1:0]                acc_q;
    logic [CNT_W-1:0]                cand_q;
    logic [CNT_W-1:0]                lane_cnt;
    logic [LANES-1:0]                hits;
    logic                            start;
    logic                            last_pt;

    assign start   = (state_q == IDLE) && bus.en;
    assign last_pt = (xg_q == COORD_W'(XSTEPS - 1)) && (y_q == COORD_W'(GRID - 1));
    assign py      = y_q + COORD_W'(1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.en) state_d = SCAN;
            SCAN:    if (last_pt) state_d = FLUSH;
            FLUSH:   if (flush_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
            v1_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= (state_q == FLUSH) ? ~flush_q : 1'b0;
            v1_q    <= (state_q == SCAN);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            central_q <= '0;
            radius_q  <= '0;
            mode_q    <= MODE_A;
            xg_q      <= '0;
            y_q       <= '0;
        end else if (start) begin
            central_q <= bus.central;
            radius_q  <= bus.radius;
            mode_q    <= mode_e'(bus.mode);
            xg_q      <= '0;
            y_q       <= '0;
        end else if (state_q == SCAN) begin
            if (xg_q == COORD_W'(XSTEPS - 1)) begin
                xg_q <= '0;
                y_q  <= y_q + COORD_W'(1);
            end else begin
                xg_q <= xg_q + COORD_W'(1);
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [COORD_W-1:0]   px;
        logic [N_CIRCLES-1:0] member;

        assign px = COORD_W'(int'(xg_q) * LANES + l + 1);

        set_point_eval #(
            .COORD_W   (COORD_W),
            .RAD_W     (RAD_W),
            .N_CIRCLES (N_CIRCLES)
        ) u_eval (
            .clk       (clk),
            .rst_n     (rst),
            .px_i      (px),
            .py_i      (py),
            .central_i (central_q),
            .radius_i  (radius_q),
            .member_o  (member)
        );

        assign hits[l] = set_expr(3'(member), mode_q);
    end

    always_comb begin
        lane_cnt = '0;
        for (int l = 0; l < LANES; l++) lane_cnt = lane_cnt + CNT_W'(hits[l]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q  <= '0;
            cand_q <= '0;
        end else begin
            if (start)     acc_q <= '0;
            else if (v1_q) acc_q <= acc_q + lane_cnt;
            if (state_q == FLUSH && flush_q) cand_q <= acc_q;
        end
    end

`ifdef SET_MAP_EN
    logic [COORD_W-1:0]   xg1_q;
    logic [COORD_W-1:0]   y1_q;
    logic [GRID*GRID-1:0] map_acc_q;
    logic [GRID*GRID-1:0] map_q;

    // Stage-1 point index follows the d2 registers so hits land on the right bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xg1_q     <= '0;
            y1_q      <= '0;
            map_acc_q <= '0;
            map_q     <= '0;
        end else begin
            xg1_q <= xg_q;
            y1_q  <= y_q;
            if (start) map_acc_q <= '0;
            else if (v1_q) begin
                for (int l = 0; l < LANES; l++)
                    map_acc_q[int'(y1_q) * GRID + int'(xg1_q) * LANES + l] <= hits[l];
            end
            if (state_q == FLUSH && flush_q) map_q <= map_acc_q;
        end
    end

    assign bus.map = map_q;
`endif

    assign bus.busy      = (state_q != IDLE);
    assign bus.valid     = (state_q == DONE);
    assign bus.candidate = cand_q;

endmodule
